reaction_timer_ctrl: RTL

Sequences one round of the reaction-time game around the 13-bit equality comparator `equals13bit`.
- Counts a random wait in millisecond ticks, using the comparator to detect when the wait ends, then lights the GO LED.
- Measures the player's response in ms, and flags false starts and timeouts.
- Sits between the debounced button inputs, the random delay source and the score display driver.

---
 rtl/reaction_timer_ctrl_pkg.sv | 20 ++
 rtl/reaction_timer_ctrl_if.sv | 39 +++
 rtl/equals13bit.sv | 10 +
 rtl/ms_prescaler.sv | 29 ++
 rtl/reaction_timer_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared types and constants for the reaction-time game controller.
package reaction_pkg;

    localparam int              MS_W             = 13;
    localparam logic [MS_W-1:0] MS_MAX           = 13'h1FFF;
    localparam int              TICK_DIV_DEFAULT = 50000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GO   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Rising-edge detect from the current level and its registered copy.
    function automatic logic rising(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Button / delay / display bundle of the reaction-time controller.
// Optional BEST_SCORE_EN adds the best_ms signal.
interface reaction_timer_ctrl_if;
    import reaction_pkg::*;

    logic            start;
    logic            react;
    logic [MS_W-1:0] target_delay;
    logic            led_on;
    logic            busy;
    logic [MS_W-1:0] result_ms;
    logic            result_valid;
    logic            false_start;
    logic            timeout;
`ifdef BEST_SCORE_EN
    logic [MS_W-1:0] best_ms;
`endif

`ifdef BEST_SCORE_EN
    modport master (
        output start, react, target_delay,
        input  led_on, busy, result_ms, result_valid, false_start, timeout, best_ms
    );
    modport slave (
        input  start, react, target_delay,
        output led_on, busy, result_ms, result_valid, false_start, timeout, best_ms
    );
`else
    modport master (
        output start, react, target_delay,
        input  led_on, busy, result_ms, result_valid, false_start, timeout
    );
    modport slave (
        input  start, react, target_delay,
        output led_on, busy, result_ms, result_valid, false_start, timeout
    );
`endif

endinterface

// File: rtl/equals13bit.sv
// 13-bit equality comparator.
module equals13bit (
    input  logic [12:0] a,
    input  logic [12:0] b,
    output logic        eq
);

    assign eq = (a == b);

endmodule

// File: rtl/ms_prescaler.sv
// Divides clk down to a one-cycle millisecond tick; clr restarts the period.
module ms_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] pre;

    assign tick = (pre == LAST);

    // Count 0..TICK_DIV-1 and wrap; a clear makes the next tick a full period away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (clr || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game round sequencer: random wait, GO LED, response
// measurement, false-start and timeout detection.
// Optional BEST_SCORE_EN keeps the lowest valid result in best_ms.
//
// state | meaning
// IDLE  | after reset, waiting for a start press
// WAIT  | counting the random delay, LED off
// GO    | LED on, measuring the response
// DONE  | result shown, waiting for the next start press
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int              TICK_DIV = TICK_DIV_DEFAULT,
    parameter logic [MS_W-1:0] MAX_MS   = MS_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    reaction_timer_ctrl_if.slave bus
);

    state_t          state;
    logic            start_q;
    logic            react_q;
    logic            start_armed;
    logic            react_armed;
    logic            start_e;
    logic            react_e;
    logic [MS_W-1:0] cnt;
    logic [MS_W-1:0] tgt_q;
    logic [MS_W-1:0] result_q;
    logic            led_q;
    logic            busy_q;
    logic            valid_q;
    logic            fs_q;
    logic            to_q;
    logic            tick;
    logic            eq;

    logic            go_start;
    logic            wait_fs;
    logic            wait_go;
    logic            go_react;
    logic            go_to;
    logic            state_chg;

    // A button held through reset release must be seen low once before it
    // can fire, so the edge detect is gated by an arm flag.
    assign start_e = rising(bus.start, start_q) & start_armed;
    assign react_e = rising(bus.react, react_q) & react_armed;

    // Edge-detect history and arm flags for both buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q     <= 1'b0;
            react_q     <= 1'b0;
            start_armed <= 1'b0;
            react_armed <= 1'b0;
        end else begin
            start_q <= bus.start;
            react_q <= bus.react;
            if (!bus.start) start_armed <= 1'b1;
            if (!bus.react) react_armed <= 1'b1;
        end
    end

    ms_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_chg),
        .tick (tick)
    );

    equals13bit u_eq (
        .a  (cnt),
        .b  (tgt_q),
        .eq (eq)
    );

    // Transition conditions for the current state; react wins over eq and timeout.
    always_comb begin
        go_start = 1'b0;
        wait_fs  = 1'b0;
        wait_go  = 1'b0;
        go_react = 1'b0;
        go_to    = 1'b0;
        case (state)
            IDLE, DONE: go_start = start_e;
            WAIT: begin
                wait_fs = react_e;
                wait_go = ~react_e & eq;
            end
            GO: begin
                go_react = react_e;
                go_to    = ~react_e & (cnt == MAX_MS);
            end
            default: ;
        endcase
        state_chg = go_start | wait_fs | wait_go | go_react | go_to;
    end

    // Millisecond counter: restarts on entry to WAIT and GO, never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (go_start || wait_go) begin
            cnt <= '0;
        end else if (tick && (state == WAIT) && (cnt != MS_MAX)) begin
            cnt <= cnt + 1'b1;
        end else if (tick && (state == GO) && (cnt != MAX_MS)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Round sequencer with registered display and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tgt_q    <= '0;
            result_q <= '0;
            led_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (go_start) begin
                        state    <= WAIT;
                        tgt_q    <= bus.target_delay;
                        result_q <= '0;
                        fs_q     <= 1'b0;
                        to_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        led_q    <= 1'b0;
                    end
                end
                WAIT: begin
                    if (wait_fs) begin
                        state    <= DONE;
                        fs_q     <= 1'b1;
                        result_q <= '0;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                    end else if (wait_go) begin
                        state <= GO;
                        led_q <= 1'b1;
                    end
                end
                GO: begin
                    if (go_react) begin
                        state    <= DONE;
                        result_q <= cnt;
                        led_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                    end else if (go_to) begin
                        state    <= DONE;
                        result_q <= MAX_MS;
                        to_q     <= 1'b1;
                        led_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.led_on       = led_q;
    assign bus.busy         = busy_q;
    assign bus.result_ms    = result_q;
    assign bus.result_valid = valid_q;
    assign bus.false_start  = fs_q;
    assign bus.timeout      = to_q;

`ifdef BEST_SCORE_EN
    logic [MS_W-1:0] best_q;

    // Lowest genuine reaction so far; updates on the same edge as result_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_q <= MS_MAX;
        end else if (go_react && (cnt < best_q)) begin
            best_q <= cnt;
        end
    end

    assign bus.best_ms = best_q;
`endif

endmodule
